// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port register-file RAM between the
// core sequencer (priority requester) and a DMA requester. Every access is a
// fixed three-cycle IDLE -> ACCESS -> COMPLETE transaction; a starvation
// counter forces a DMA grant after STARVE_LIMIT consecutive core wins taken
// while DMA was also waiting.
module ram_port_arbiter #(
    parameter int unsigned AW           = 4,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          C_REQ,
    input  logic          C_WE,
    input  logic [AW-1:0] C_ADDR,
    input  logic [DW-1:0] C_WDATA,
    output logic          C_GNT,
    output logic          C_DONE,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_DONE,
    output logic [DW-1:0] RDATA,
    output logic          RAM_CS,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_WDATA,
    input  logic [DW-1:0] RAM_RDATA,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state;
    logic          owner_dma;
    logic [3:0]    starve_cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          ram_cs_q;
    logic          ram_we_q;
    logic          c_gnt_q;
    logic          d_gnt_q;
    logic          c_done_q;
    logic          d_done_q;
    logic          dma_wins;

    // DMA wins when it is alone, or when the core has used up its starvation allowance
    always_comb begin
        dma_wins = D_REQ && (!C_REQ || (starve_cnt == LIMIT));
    end

    // Transaction FSM; handshake and RAM strobes are registered so reset clears them at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            owner_dma  <= 1'b0;
            starve_cnt <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            c_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            c_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (C_REQ || D_REQ) begin
                        owner_dma <= dma_wins;
                        we_q      <= dma_wins ? D_WE    : C_WE;
                        addr_q    <= dma_wins ? D_ADDR  : C_ADDR;
                        wdata_q   <= dma_wins ? D_WDATA : C_WDATA;
                        ram_cs_q  <= 1'b1;
                        ram_we_q  <= dma_wins ? D_WE    : C_WE;
                        c_gnt_q   <= !dma_wins;
                        d_gnt_q   <= dma_wins;
                        if (dma_wins || !D_REQ) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != LIMIT) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= RAM_RDATA;
                    end
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    c_gnt_q  <= 1'b0;
                    d_gnt_q  <= 1'b0;
                    c_done_q <= !owner_dma;
                    d_done_q <= owner_dma;
                    state    <= COMPLETE;
                end
                COMPLETE: begin
                    c_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Address and write data are only presented to the RAM while it is selected
    always_comb begin
        RAM_ADDR  = ram_cs_q ? addr_q  : '0;
        RAM_WDATA = ram_cs_q ? wdata_q : '0;
    end

    assign RAM_CS = ram_cs_q;
    assign RAM_WE = ram_we_q;
    assign C_GNT  = c_gnt_q;
    assign D_GNT  = d_gnt_q;
    assign C_DONE = c_done_q;
    assign D_DONE = d_done_q;
    assign RDATA  = rdata_q;
    assign BUSY   = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: the stimulus process runs a
// transaction-level arbitration model (slot timing, priority, starvation
// allowance, reference memory) and queues the expected transaction; a
// negedge monitor pops and compares whatever the DUT presents.
module tb_ram_port_arbiter;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned LIMIT = 3;

    logic          CLK;
    logic          RST;
    logic          C_REQ, C_WE, D_REQ, D_WE;
    logic [AW-1:0] C_ADDR, D_ADDR;
    logic [DW-1:0] C_WDATA, D_WDATA;
    logic          C_GNT, C_DONE, D_GNT, D_DONE;
    logic [DW-1:0] RDATA;
    logic          RAM_CS, RAM_WE;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_WDATA;
    logic [DW-1:0] RAM_RDATA;
    logic          BUSY;

    ram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .C_REQ(C_REQ), .C_WE(C_WE), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
        .C_GNT(C_GNT), .C_DONE(C_DONE),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_DONE(D_DONE),
        .RDATA(RDATA),
        .RAM_CS(RAM_CS), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural RAM attached to the DUT pins
    logic [DW-1:0] ram [16];
    assign RAM_RDATA = ram[RAM_ADDR];
    always @(posedge CLK) begin
        if (RAM_CS && RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
    end

    typedef struct {
        bit            who;     // 0 core, 1 DMA
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;   // RDATA expected during COMPLETE
        logic [DW-1:0] old;     // memory content before a write, for abort rollback
        int            arb_cyc;
    } txn_t;

    txn_t          sb[$];
    txn_t          cur;
    bit            pending_done;
    bit            glog[$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_rdata;
    int            cyc;
    int            next_arb;
    int            starve;
    int            tests;
    int            fails;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge; the model arbitrates from the inputs seen at that edge
    task automatic step();
        txn_t t;
        bit   win_d;
        @(posedge CLK);
        cyc++;
        if (RST && cyc >= next_arb && (C_REQ || D_REQ)) begin
            win_d = (C_REQ && D_REQ) ? (starve == LIMIT) : D_REQ;
            if (win_d || !D_REQ) starve = 0;
            else if (starve < LIMIT) starve = starve + 1;
            t.who     = win_d;
            t.we      = win_d ? D_WE : C_WE;
            t.addr    = win_d ? D_ADDR : C_ADDR;
            t.wdata   = win_d ? D_WDATA : C_WDATA;
            t.old     = ref_mem[t.addr];
            t.arb_cyc = cyc;
            if (t.we) ref_mem[t.addr] = t.wdata;
            else exp_rdata = ref_mem[t.addr];
            t.rdata   = exp_rdata;
            sb.push_back(t);
            next_arb  = cyc + 3;
        end
        #1;
    endtask

    // Asynchronous reset mid-cycle; any not-yet-completed ACCESS is rolled back in the model
    task automatic apply_reset();
        #1 RST = 1'b0;
        #1 check("reset_async_outputs",
                 {C_GNT, C_DONE, D_GNT, D_DONE, RAM_CS, RAM_WE, BUSY, RAM_ADDR, RAM_WDATA, RDATA}, 64'd0);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].we) ref_mem[sb[i].addr] = sb[i].old;
        end
        sb.delete();
        pending_done = 1'b0;
        starve       = 0;
        next_arb     = 0;
        exp_rdata    = '0;
        step();
        check("reset_held_outputs",
              {C_GNT, C_DONE, D_GNT, D_DONE, RAM_CS, RAM_WE, BUSY, RDATA}, 64'd0);
        #2 RST = 1'b1;
    endtask

    task automatic set_inputs(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        C_REQ = cr; C_WE = cw; C_ADDR = ca; C_WDATA = cd;
        D_REQ = dr; D_WE = dw; D_ADDR = da; D_WDATA = dd;
    endtask

    task automatic check_order(input string name, input int base, input int n, input logic [7:0] pat);
        check({name, "_count"}, (glog.size() >= base + n) ? 64'd1 : 64'd0, 64'd1);
        for (int i = 0; i < n; i++) begin
            if (base + i < glog.size()) check(name, {63'd0, glog[base + i]}, {63'd0, pat[i]});
        end
    endtask

    // Monitor: every cycle is either a grant, a completion, or must be quiet
    always @(negedge CLK) begin
        if (RST) begin
            if (pending_done) begin
                check("done_ctl", {C_GNT, D_GNT, C_DONE, D_DONE, RAM_CS, RAM_WE, BUSY},
                      {2'b00, !cur.who, cur.who, 2'b00, 1'b1});
                check("done_rdata", RDATA, cur.rdata);
                pending_done = 1'b0;
            end else if (sb.size() != 0 && sb[0].arb_cyc == cyc) begin
                cur = sb.pop_front();
                check("gnt_ctl", {C_GNT, D_GNT, C_DONE, D_DONE, RAM_CS, RAM_WE, BUSY},
                      {!cur.who, cur.who, 2'b00, 1'b1, cur.we, 1'b1});
                check("gnt_addr", RAM_ADDR, cur.addr);
                check("gnt_wdata", RAM_WDATA, cur.wdata);
                glog.push_back(cur.who);
                pending_done = 1'b1;
            end else begin
                check("idle_ctl", {C_GNT, D_GNT, C_DONE, D_DONE, RAM_CS, RAM_WE, BUSY}, 64'd0);
            end
        end
    end

    initial begin
        int base;
        tests = 0; fails = 0; cyc = 0; next_arb = 0; starve = 0;
        pending_done = 1'b0; exp_rdata = '0;
        for (int a = 0; a < 16; a++) begin
            ram[a]     = 8'($urandom);
            ref_mem[a] = ram[a];
        end
        RST = 1'b0;
        set_inputs(1, 0, 4'h1, 8'h11, 1, 0, 4'h2, 8'h22);

        // Reset with both requesters asserted, then continuous contention
        step(); step();
        check("reset_outputs",
              {C_GNT, C_DONE, D_GNT, D_DONE, RAM_CS, RAM_WE, BUSY, RAM_ADDR, RAM_WDATA, RDATA}, 64'd0);
        #2 RST = 1'b1;
        base = glog.size();
        for (int i = 0; i < 24; i++) begin
            set_inputs(1, 1'($urandom), 4'($urandom), 8'($urandom),
                       1, 1'($urandom), 4'($urandom), 8'($urandom));
            step();
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        check_order("contention_order", base, 8, 8'b1000_1000);

        // Core read with REQ held only for the arbitration edge
        ram[4'hA] = 8'h5C; ref_mem[4'hA] = 8'h5C;
        set_inputs(1, 0, 4'hA, 8'hFF, 0, 0, 0, 0);
        step();
        set_inputs(0, 1, 4'h0, 8'h00, 0, 0, 0, 0);
        repeat (5) step();

        // DMA write: RDATA must keep the 5C read before it
        set_inputs(0, 0, 0, 0, 1, 1, 4'h3, 8'hA7);
        step();
        set_inputs(0, 0, 0, 0, 0, 0, 4'h9, 8'h00);
        repeat (4) step();
        check("dma_write_mem", ram[4'h3], 8'hA7);

        // Build the starvation count with core writes, then reset during the third write's ACCESS
        for (int i = 0; i < 7; i++) begin
            set_inputs(1, 1, 4'h5, 8'($urandom), 1, 0, 4'($urandom), 8'($urandom));
            step();
        end
        apply_reset();
        check("abort_no_write", ram[4'h5], ref_mem[4'h5]);
        base = glog.size();
        for (int i = 0; i < 12; i++) begin
            set_inputs(1, 1'($urandom), 4'($urandom), 8'($urandom),
                       1, 1'($urandom), 4'($urandom), 8'($urandom));
            step();
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        check_order("post_reset_order", base, 4, 8'b0000_1000);

        // Randomised traffic, biased toward contention
        for (int i = 0; i < 400; i++) begin
            set_inputs(($urandom % 4) != 0, 1'($urandom), 4'($urandom), 8'($urandom),
                       ($urandom % 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom));
            step();
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step();
        check("drain_queue", sb.size(), 0);
        check("drain_done", {63'd0, pending_done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port register-file RAM between the core sequence controller and an I/O-side DMA requester.
- Sits between both requesters and the RAM chip-select, write-enable, address and data pins.
- Serialises accesses into fixed 3-cycle transactions with a REQ/GNT/DONE handshake.
- The core has priority. A starvation counter forces a DMA grant after a bounded number of consecutive core wins.

Parameters:
AW, 4, RAM address width
DW, 8, RAM data width
STARVE_LIMIT, 3, consecutive core grants allowed while DMA is pending before DMA wins (range 1..15)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
C_REQ  input  1  core request; held until C_DONE
C_WE  input  1  core write (1) / read (0)
C_ADDR  input  AW  core address
C_WDATA  input  DW  core write data
C_GNT  output  1  core transaction in ACCESS phase
C_DONE  output  1  core transaction complete, one-cycle pulse
D_REQ  input  1  DMA request; held until D_DONE
D_WE  input  1  DMA write / read
D_ADDR  input  AW  DMA address
D_WDATA  input  DW  DMA write data
D_GNT  output  1  DMA transaction in ACCESS phase
D_DONE  output  1  DMA transaction complete, one-cycle pulse
RDATA  output  DW  read data of the last completed read (shared)
RAM_CS  output  1  RAM chip select
RAM_WE  output  1  RAM write enable
RAM_ADDR  output  AW  RAM address
RAM_WDATA  output  DW  RAM write data
RAM_RDATA  input  DW  RAM asynchronous read data, valid while RAM_CS is high
BUSY  output  1  state is not IDLE

Behaviour:
- Reset (RST=0, asynchronous, any time):
  - state=IDLE; owner=core; starve_cnt=0; latched WE/ADDR/WDATA=0.
  - RDATA=0; every output is 0.
  - A transaction in progress is abandoned: RAM_CS and RAM_WE drop immediately and no DONE is issued.
- States: IDLE -> ACCESS -> COMPLETE -> IDLE. Each transaction takes exactly 3 cycles, so maximum throughput is 1 access per 3 cycles.
- IDLE:
  - No outputs are asserted.
  - At the rising edge, if C_REQ or D_REQ is high, the arbiter picks a winner, latches that requester's WE/ADDR/WDATA, and moves to ACCESS. Otherwise it stays in IDLE.
- Arbitration at the IDLE edge:
  - Only C_REQ high: core wins.
  - Only D_REQ high: DMA wins.
  - Both high: DMA wins if starve_cnt==STARVE_LIMIT, otherwise core wins.
- starve_cnt update, at arbitration only:
  - Core win with D_REQ high: increment, saturating at STARVE_LIMIT.
  - DMA win: reset to 0.
  - Core win with D_REQ low: reset to 0.
- ACCESS:
  - RAM_CS=1; RAM_WE=latched WE; RAM_ADDR and RAM_WDATA driven from the latched fields.
  - The winner's GNT is high.
  - At the edge: if latched WE=0, RDATA<=RAM_RDATA. For a write, RDATA holds its previous value.
- COMPLETE:
  - RAM_CS=0; the winner's DONE is high.
  - RDATA is valid for a read.
  - The state goes to IDLE at the next edge.
- Timing: REQ sampled at edge k gives GNT in cycle k..k+1, DONE in cycle k+1..k+2, and IDLE in cycle k+2..k+3.
- Handshake rules:
  - A requester that wants no further access drops REQ before the end of its IDLE cycle.
  - REQ still high at the IDLE edge counts as a new transaction, so back-to-back requests cost 3 cycles each.
  - Dropping REQ during ACCESS or COMPLETE does not abort; the transaction finishes and DONE still pulses.
  - Changes to WE/ADDR/WDATA after the grant edge are ignored.
- Exclusivity: GNT and DONE are never high for both requesters in the same cycle, and GNT and DONE never overlap.
- Address wrap: none; the address is passed through unmodified.

Test Plan:
- Reset: RST=0 with both REQ high -> all outputs 0, RDATA=8'h00, BUSY=0. After RST=1, the first grant goes to the core.
- Core read: C_REQ=1, C_WE=0, C_ADDR=4'hA, RAM_RDATA=8'h5C -> next cycle RAM_CS=1, RAM_ADDR=4'hA, C_GNT=1. Following cycle C_DONE=1, RDATA=8'h5C. Then IDLE.
- DMA write: D_REQ=1, D_WE=1, D_ADDR=4'h3, D_WDATA=8'hA7 -> one ACCESS cycle with RAM_WE=1, RAM_ADDR=4'h3, RAM_WDATA=8'hA7. Then D_DONE=1 with RDATA unchanged.
- Contention: C_REQ and D_REQ held high continuously, STARVE_LIMIT=3 -> grant order C,C,C,D,C,C,C,D. GNT pulses every 3 cycles, never both GNTs high together.
- Reset during a write: RST falls mid-ACCESS -> RAM_CS and RAM_WE go to 0 asynchronously and no DONE pulses. After release the arbiter re-arbitrates from IDLE with starve_cnt=0.
- Request drop: C_REQ pulsed high for only the arbitration edge -> the full transaction still completes with C_DONE=1, then the arbiter stays in IDLE.
